// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions.
// Holds the funct3 encodings for loads and stores, the LSU state enum,
// and two pure helper functions used by the LSU front end:
//   lsu_req_err    - decides whether a request is illegal (bad op, misaligned,
//                    or outside the addressable memory)
//   lsu_store_lanes - replicates store data across the four byte lanes
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    LOAD_DATA = 2'd2
  } lsu_state_e;

  function automatic logic lsu_req_err(input logic        we,
                                       input logic [2:0]  op,
                                       input logic [31:0] addr,
                                       input logic [31:0] mem_size);
    logic err;
    err = 1'b0;
    if (!we && (op == 3'b011 || op == 3'b110 || op == 3'b111)) err = 1'b1;
    if (we && !(op == F3_B || op == F3_H || op == F3_W))       err = 1'b1;
    if ((op == F3_H || op == F3_HU) && addr[0])                err = 1'b1;
    if (op == F3_W && addr[1:0] != 2'b00)                      err = 1'b1;
    if (addr >= mem_size)                                      err = 1'b1;
    return err;
  endfunction

  // The RAM writes whole lanes under a byte mask, so the store data is
  // copied into every lane it could land in; the mask picks the real one.
  function automatic logic [31:0] lsu_store_lanes(input logic [2:0]  op,
                                                  input logic [31:0] wdata);
    logic [31:0] lanes;
    case (op)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction and extension.
// Ports:
//   rdata [31:0] in  - raw word read from the RAM
//   addr  [1:0]  in  - byte offset of the load within the word
//   op    [2:0]  in  - RV32 funct3 of the load
//   data  [31:0] out - lane shifted down to bit 0, sign/zero extended
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (op)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-wide RAM with 1-cycle read latency.
// Ports:
//   clk, rst                  - rising-edge clock, synchronous active-high reset
//   req_valid_i / req_ready_o - request handshake; a transfer happens on a
//                               rising edge where both are 1. ready is high
//                               only in IDLE, and request inputs are ignored
//                               while it is low. No backpressure on responses.
//   req_we_i, req_op_i, req_addr_i, req_wdata_i - request payload
//   rsp_valid_o               - one-cycle registered response pulse
//   rsp_rdata_o, rsp_err_o    - response payload, held until the next response
//   mem_addr_o, mem_rstrb_o, mem_rdata_i, mem_wmask_o, mem_wdata_o - RAM side
//   state_dbg_o               - current FSM state, for observation only
// Latency: error T+1, store T+2, load T+3 from the transfer cycle T.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_SIZE = `MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  state_dbg_o
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] align_data;
  logic        req_err;

  load_align u_load_align (
    .rdata (mem_rdata_i),
    .addr  (off_q),
    .op    (op_q),
    .data  (align_data)
  );

  assign req_err = lsu_req_err(req_we_i, req_op_i, req_addr_i, MEM_SIZE);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    op_d        = op_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rstrb_o = 1'b0;
    mem_wmask_o = 4'b0000;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d  = req_we_i;
          op_d  = req_op_i;
          off_d = req_addr_i[1:0];
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d    = ISSUE;
            // RAM address/data are registered here so they only move when a
            // real access starts and otherwise hold their last values.
            mem_addr_d = {req_addr_i[31:2], 2'b00};
            if (req_we_i) mem_wdata_d = lsu_store_lanes(req_op_i, req_wdata_i);
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          case (op_q)
            F3_B:    mem_wmask_o = 4'(4'b0001 << off_q);
            F3_H:    mem_wmask_o = 4'(4'b0011 << off_q);
            default: mem_wmask_o = 4'b1111;
          endcase
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          state_d     = IDLE;
        end else begin
          mem_rstrb_o = 1'b1;
          state_d     = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = align_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset landing on the ISSUE cycle must not let the access reach the RAM.
    if (rst) begin
      mem_rstrb_o = 1'b0;
      mem_wmask_o = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized traffic against a
// byte-array reference memory. Expected responses are queued at issue time and
// a separate monitor compares them whenever rsp_valid_o is seen.
module tb_load_store_unit;

  localparam int unsigned MEM = 256;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_addr_o;
  logic        mem_rstrb_o;
  logic [31:0] mem_rdata_i;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  state_dbg_o;

  load_store_unit #(.MEM_SIZE(MEM)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_op_i    (req_op_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rstrb_o (mem_rstrb_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_wmask_o (mem_wmask_o),
    .mem_wdata_o (mem_wdata_o),
    .state_dbg_o (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- word RAM (1-cycle registered read) ----------------
  logic [31:0] ram [MEM/4];
  logic        ram_init_done = 1'b0;

  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int w = 0; w < MEM/4; w++) ram[w] <= init_word(w);
      ram_init_done <= 1'b1;
    end else begin
      if (mem_rstrb_o) mem_rdata_i <= ram[mem_addr_o[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MEM];

  function automatic int op_size(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input bit we, input logic [2:0] op, input logic [31:0] a);
    bit e = 0;
    if (!we && (op == 3'b011 || op == 3'b110 || op == 3'b111)) e = 1;
    if (we && op > 3'b010) e = 1;
    if ((op == 3'b001 || op == 3'b101) && a % 2 != 0) e = 1;
    if (op == 3'b010 && a % 4 != 0) e = 1;
    if (a >= MEM) e = 1;
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    int n = op_size(op);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (!op[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!op[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [3:0] ref_wmask(input logic [2:0] op, input logic [31:0] a);
    logic [3:0] m = 0;
    for (int i = 0; i < op_size(op); i++) m[(a % 4) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wlanes(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] v = 0;
    int n = op_size(op);
    for (int b = 0; b < 4; b++) v[8*b +: 8] = d[8*(b % n) +: 8];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [$];   // {err, rdata}
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err_o), 32'(e[32]));
        chk("rsp_rdata", rsp_rdata_o, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic garbage();
    req_valid_i = 1'b1;
    req_we_i    = 1'($urandom);
    req_op_i    = 3'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
  endtask

  // One request; use_exp replaces the model value with a directed constant.
  task automatic do_req(input bit we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit use_exp, input logic [31:0] exp_val);
    bit e;
    logic [31:0] rd;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready_o), 32'h1);
    req_valid_i = 1'b1; req_we_i = we; req_op_i = op; req_addr_i = a; req_wdata_i = d;
    e  = ref_err(we, op, a);
    rd = 32'h0;
    if (!e && !we) rd = use_exp ? exp_val : ref_load(op, a);
    exp_q.push_back({e, rd});
    @(posedge clk);
    @(negedge clk);                     // T+1
    if (e) begin
      chk("err_rsp_valid_t1", 32'(rsp_valid_o), 32'h1);
      chk("err_no_rstrb", 32'(mem_rstrb_o), 32'h0);
      chk("err_no_wmask", 32'(mem_wmask_o), 32'h0);
      req_valid_i = 1'b0;
    end else if (we) begin
      chk("st_wmask", 32'(mem_wmask_o), 32'(ref_wmask(op, a)));
      chk("st_addr", mem_addr_o, a & ~32'h3);
      chk("st_wdata", mem_wdata_o, ref_wlanes(op, d));
      chk("st_rsp_valid_t1", 32'(rsp_valid_o), 32'h0);
      for (int i = 0; i < op_size(op); i++) ref_mem[a + i] = d[8*i +: 8];
      garbage();
      @(negedge clk);                   // T+2
      chk("st_rsp_valid_t2", 32'(rsp_valid_o), 32'h1);
      chk("st_wmask_off", 32'(mem_wmask_o), 32'h0);
      req_valid_i = 1'b0;
    end else begin
      chk("ld_rstrb", 32'(mem_rstrb_o), 32'h1);
      chk("ld_addr", mem_addr_o, a & ~32'h3);
      chk("ld_no_wmask", 32'(mem_wmask_o), 32'h0);
      garbage();
      @(negedge clk);                   // T+2
      chk("ld_rstrb_off", 32'(mem_rstrb_o), 32'h0);
      chk("ld_rsp_valid_t2", 32'(rsp_valid_o), 32'h0);
      garbage();
      @(negedge clk);                   // T+3
      chk("ld_rsp_valid_t3", 32'(rsp_valid_o), 32'h1);
      req_valid_i = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'h1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, "_rdata"}, rsp_rdata_o, 32'h0);
    chk({tag, "_err"}, 32'(rsp_err_o), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, "_rstrb"}, 32'(mem_rstrb_o), 32'h0);
    chk({tag, "_wmask"}, 32'(mem_wmask_o), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] addrs [5];
    bit we;
    logic [2:0] op;

    for (int w = 0; w < MEM/4; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8 * b);

    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_op_i = 3'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk_reset_outputs("reset");

    // Directed: word store, byte/half loads and stores
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    do_req(0, 3'b000, 32'h13, 0, 1, 32'hFFFFFFDE);
    do_req(0, 3'b100, 32'h13, 0, 1, 32'h000000DE);
    do_req(1, 3'b001, 32'h16, 32'h0000A5C3, 0, 0);
    do_req(0, 3'b001, 32'h16, 0, 1, 32'hFFFFA5C3);
    do_req(0, 3'b101, 32'h16, 0, 1, 32'h0000A5C3);
    do_req(0, 3'b010, 32'h10, 0, 1, 32'hDEADBEEF);

    // Directed errors
    do_req(0, 3'b010, 32'h11, 0, 0, 0);
    do_req(1, 3'b001, 32'h13, 32'h1234, 0, 0);
    do_req(0, 3'b000, MEM, 0, 0, 0);
    do_req(0, 3'b011, 32'h20, 0, 0, 0);
    do_req(1, 3'b100, 32'h20, 32'h55, 0, 0);

    // Reset in the LOAD_DATA cycle aborts the load
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_op_i = 3'b010; req_addr_i = 32'h20;
    @(posedge clk);
    @(negedge clk); req_valid_i = 1'b0;             // ISSUE
    @(negedge clk); rst = 1'b1;                     // LOAD_DATA
    @(negedge clk); rst = 1'b0;
    chk_reset_outputs("abort_ld");
    @(negedge clk);
    chk("abort_ld_no_rsp", 32'(rsp_valid_o), 32'h0);
    do_req(1, 3'b010, 32'h24, 32'hCAFEF00D, 0, 0);
    do_req(0, 3'b010, 32'h24, 0, 1, 32'hCAFEF00D);

    // Reset in the ISSUE cycle of a store blocks the write
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_op_i = 3'b010; req_addr_i = 32'h30;
    req_wdata_i = ~ref_load(3'b010, 32'h30);
    @(posedge clk);
    @(negedge clk); req_valid_i = 1'b0; rst = 1'b1;  // ISSUE
    #1 chk("abort_st_wmask", 32'(mem_wmask_o), 32'h0);
    @(negedge clk); rst = 1'b0;
    chk_reset_outputs("abort_st");
    do_req(0, 3'b010, 32'h30, 0, 0, 0);

    // Five back-to-back LWs with req_valid held high
    for (int i = 0; i < 5; i++) addrs[i] = 32'(4 * $urandom_range(0, MEM/4 - 1));
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_op_i = 3'b010; req_addr_i = addrs[0];
    exp_q.push_back({1'b0, ref_load(3'b010, addrs[0])});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("b2b_t1", 32'(rsp_valid_o), 32'h0);
      @(negedge clk); chk("b2b_t2", 32'(rsp_valid_o), 32'h0);
      @(negedge clk); chk("b2b_t3", 32'(rsp_valid_o), 32'h1);
      chk("b2b_ready", 32'(req_ready_o), 32'h1);
      if (i < 4) begin
        req_addr_i = addrs[i + 1];
        exp_q.push_back({1'b0, ref_load(3'b010, addrs[i + 1])});
      end else begin
        req_valid_i = 1'b0;
      end
    end

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      op = (($urandom_range(0, 9)) == 0) ? 3'($urandom) :
           (we ? 3'($urandom_range(0, 2)) : 3'({1'($urandom), 2'($urandom_range(0, 2))}));
      a  = ($urandom_range(0, 19) == 0) ? MEM + $urandom_range(0, 1000) : $urandom_range(0, MEM - 1);
      if ($urandom_range(0, 3) != 0) begin
        if (op_size(op) == 2) a = a & ~32'h1;
        if (op_size(op) == 4) a = a & ~32'h3;
      end
      do_req(we, op, a, $urandom, 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("leftover_expected", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default `MEM_SIZE, bytes of addressable memory; accesses with addr >= MEM_SIZE are errors.
REQ-002 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid_i in 1 and req_ready_o out 1, the core request handshake.
REQ-005 SHALL have port req_we_i  in  1  1=store, 0=load.
REQ-006 SHALL have port req_op_i  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have ports req_addr_i in 32 (byte address) and req_wdata_i in 32 (store data, LSB-aligned).
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_rdata_o out 32 and rsp_err_o out 1, the response.
REQ-009 SHALL have ports mem_addr_o out 32, mem_rstrb_o out 1, mem_rdata_i in 32, mem_wmask_o out 4 and mem_wdata_o out 32, the word-RAM side (1-cycle registered read).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, LOAD_DATA.
REQ-011 SHALL assert req_ready_o only in IDLE; a transfer is req_valid_i && req_ready_o at cycle T, capturing we/op/addr/wdata into registers.
REQ-012 SHALL flag an error on: load op in {011,110,111}; store op not in {000,001,010}; H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= MEM_SIZE.
REQ-013 On error SHALL perform no memory access, stay in IDLE and drive rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 in cycle T+1.
REQ-014 Otherwise SHALL go IDLE->ISSUE; in ISSUE, mem_addr_o = {addr[31:2],2'b00}.
REQ-015 A store in ISSUE (T+1) SHALL drive mem_wmask_o: B = 0001<<addr[1:0], H = 0011<<addr[1:0], W = 1111; mem_wdata_o = byte replicated x4, half replicated x2, or word; then return to IDLE with rsp_valid_o=1, rsp_err_o=0, rsp_rdata_o=0 in T+2.
REQ-016 A load in ISSUE SHALL drive mem_rstrb_o=1 and go to LOAD_DATA (T+2), sample mem_rdata_i there, and return to IDLE with rsp_valid_o=1 in T+3.
REQ-017 Load data SHALL be the lane shifted right by 8*addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-018 rsp_valid_o SHALL be a registered one-cycle pulse with no backpressure; rsp_rdata_o and rsp_err_o hold until the next response.
REQ-019 mem_rstrb_o and mem_wmask_o SHALL be 0 outside ISSUE; mem_addr_o and mem_wdata_o hold their last values.
REQ-020 req_ready_o SHALL be 1 in the same cycle as rsp_valid_o, giving back-to-back throughput of 1 request per 3 cycles (load), 2 (store) or 1 (error).
REQ-021 req_* inputs SHALL be ignored while req_ready_o=0.

Reset
REQ-022 rst SHALL force IDLE, and in the following cycle all outputs SHALL be 0 except req_ready_o=1.
REQ-023 rst during ISSUE or LOAD_DATA SHALL abort the access with no response; a write in progress during the reset cycle SHALL have mem_wmask_o=0.

Structure
REQ-024 The shared package riscv_pkg SHALL hold the funct3 load/store encodings and the LSU state enum.
REQ-025 Combinational lane extract/extend SHALL live in sub-module load_align (inputs rdata, addr[1:0], op; output 32-bit data).

Verification
REQ-026 Bench SHALL check: SW addr 0x10 data 0xDEADBEEF -> T+1 wmask 1111, mem_addr 0x10; T+2 rsp_valid, err 0.
REQ-027 Bench SHALL check: after REQ-026, LB addr 0x13 -> rstrb at T+1, rsp_rdata 0xFFFFFFDE at T+3; LBU addr 0x13 -> 0x000000DE.
REQ-028 Bench SHALL check: SH addr 0x16 data 0x0000A5C3 -> wmask 1100, wdata 0xA5C3A5C3; LH addr 0x16 -> 0xFFFFA5C3; LHU -> 0x0000A5C3.
REQ-029 Bench SHALL check: LW addr 0x11, SH addr 0x13, LB addr MEM_SIZE, and load op 011 -> rsp at T+1, err 1, rdata 0, no rstrb/wmask.
REQ-030 Bench SHALL check: rst asserted in the LOAD_DATA cycle -> no rsp_valid, req_ready 1 after reset, and the next SW completes normally.
REQ-031 Bench SHALL check: req_valid held high for 5 back-to-back LWs -> one rsp per 3 cycles with data matching a reference memory model.
